// File: rtl/mfun_seq_ctrl.sv
// Sequencer for the mfun M-sequence step unit: owns the LFSR state, counts
// rising edges of mf_control as steps, and collects the emitted bits into a word.
module mfun_seq_ctrl #(
    parameter int WORD_BITS = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           seed,
    input  logic [3:0]           poly,
    input  logic [5:0]           len,
    output logic [3:0]           mf_fase,
    output logic [3:0]           mf_type,
    input  logic [3:0]           mf_fase_new,
    input  logic                 mf_sum,
    input  logic                 mf_control,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WORD_BITS-1:0] data_out,
    output logic [5:0]           bit_cnt,
    output logic [4:0]           period,
    output logic                 period_valid
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [5:0] WORD_BITS_6 = 6'(WORD_BITS);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [3:0]  seed_r;
    logic [5:0]  nbits;
    logic        ctrl_d;
    logic [7:0]  to_cnt;
    logic [4:0]  step_cnt;

    logic        step;
    logic [3:0]  seed_fix;
    logic [4:0]  step_next;
    logic [5:0]  bit_next;

    // An all-zero seed would lock the LFSR, so it is replaced by 0001.
    assign seed_fix  = (seed == 4'd0) ? 4'b0001 : seed;
    assign step      = mf_control & ~ctrl_d;
    assign step_next = (step_cnt == 5'd31) ? 5'd31 : step_cnt + 5'd1;
    assign bit_next  = bit_cnt + 6'd1;
    assign busy      = (state == LOAD) || (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            seed_r       <= 4'd0;
            nbits        <= 6'd0;
            ctrl_d       <= 1'b0;
            to_cnt       <= 8'd0;
            step_cnt     <= 5'd0;
            mf_fase      <= 4'd0;
            mf_type      <= 4'd0;
            done         <= 1'b0;
            err          <= 1'b0;
            data_out     <= '0;
            bit_cnt      <= 6'd0;
            period       <= 5'd0;
            period_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    seed_r       <= seed_fix;
                    mf_fase      <= seed_fix;
                    mf_type      <= poly;
                    nbits        <= (len == 6'd0 || len > WORD_BITS_6) ? WORD_BITS_6 : len;
                    data_out     <= '0;
                    bit_cnt      <= 6'd0;
                    period       <= 5'd0;
                    period_valid <= 1'b0;
                    err          <= 1'b0;
                    to_cnt       <= 8'd0;
                    step_cnt     <= 5'd0;
                    // A strobe already high on entry must not count as a step.
                    ctrl_d       <= mf_control;
                    state        <= RUN;
                end
                RUN: begin
                    ctrl_d <= mf_control;
                    if (step) begin
                        mf_fase  <= mf_fase_new;
                        data_out <= {data_out[WORD_BITS-2:0], mf_sum};
                        bit_cnt  <= bit_next;
                        to_cnt   <= 8'd0;
                        step_cnt <= step_next;
                        if (!period_valid && mf_fase_new == seed_r) begin
                            period       <= step_next;
                            period_valid <= 1'b1;
                        end
                        if (bit_next == nbits) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else if (to_cnt == TIMEOUT_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mfun_seq_ctrl.md
Name: mfun_seq_ctrl

Overview:
- Sequencer for the `mfun` M-sequence step unit.
- Holds the LFSR state register and feeds it to `mfun` as `fase`, with the polynomial as `type_f`.
- Advances the state on each rising edge of `mfun.control`, shifts each `sum` bit into a word buffer, and reports a completed word, the sequence period and a timeout error.
- Sits between the configuration/CPU side and one `mfun` instance.

Parameters:
- WORD_BITS, 32, width of the collected output word (legal 2..32).
- TIMEOUT, 255, RUN cycles allowed between consecutive steps before aborting with error (legal 2..255).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a run; honoured only in IDLE
- seed  in  4  initial LFSR state
- poly  in  4  feedback polynomial, forwarded to mfun type_f
- len  in  6  number of bits to collect; 0 or values > WORD_BITS mean WORD_BITS
- mf_fase  out  4  current state to mfun.fase
- mf_type  out  4  latched polynomial to mfun.type_f
- mf_fase_new  in  4  next state from mfun.fase_new
- mf_sum  in  1  output bit from mfun.sum
- mf_control  in  1  step strobe from mfun.control (level, may be multi-cycle)
- busy  out  1  high in LOAD and RUN
- done  out  1  one-cycle pulse at end of run (normal or error)
- err  out  1  timeout flag, valid from done until next start
- data_out  out  WORD_BITS  collected bits, LSB = newest; valid from done until next start
- bit_cnt  out  6  bits collected so far in current run
- period  out  5  steps until state first returned to seed; 0 = not observed
- period_valid  out  1  period captured this run

Behaviour:

Reset (rst=1 at a clk edge):
- State goes to IDLE.
- All outputs become 0, including data_out, mf_fase, mf_type, period and err.
- The internal edge-detect register and counters clear.
- Reset mid-RUN abandons the run; no done pulse is produced.

FSM states: IDLE, LOAD, RUN, DONE.
- IDLE -> LOAD on start=1.
- LOAD (1 cycle):
  - seed_r <= (seed==0) ? 4'b0001 : seed, because the all-zero state locks up the LFSR.
  - state register <= seed_r value; mf_type <= poly.
  - nbits <= (len==0 || len>WORD_BITS) ? WORD_BITS : len.
  - Clear data_out, bit_cnt, period, period_valid, err and the timeout counter.
  - ctrl_d <= mf_control, so a strobe already high on entry is not counted.
  - Then go to RUN.
- RUN:
  - step = mf_control & ~ctrl_d; ctrl_d <= mf_control every cycle.
  - On step:
    - state <= mf_fase_new.
    - data_out <= {data_out[WORD_BITS-2:0], mf_sum}.
    - bit_cnt <= bit_cnt+1; timeout counter <= 0.
    - step_cnt <= step_cnt+1 (5 bit, saturating at 31).
    - If !period_valid && mf_fase_new==seed_r: period <= step_cnt+1, period_valid <= 1.
    - If bit_cnt+1 == nbits: go to DONE.
  - No step: timeout counter increments. When it reaches TIMEOUT-1 (i.e. TIMEOUT consecutive RUN cycles without a step), go to DONE with err <= 1.
  - Step and timeout in the same cycle: the step wins, the counter clears and err stays 0.
- DONE (1 cycle): done=1, then go to IDLE.
- mf_fase = state register continuously; it holds its value in IDLE and DONE.
- start in LOAD, RUN or DONE is ignored and not queued.
- start in the same cycle as rst: reset wins.
- busy is combinational from state; done and err are registered.

Test Plan:
1. rst, then start with seed=0101, poly=0101, len=8; bench drives 8 one-cycle mf_control pulses with mf_sum=1,0,1,1,0,0,1,0 -> done after the 8th step, data_out=0x000000B2, bit_cnt=8, err=0.
2. Seed=0000 -> mf_fase=0001 in RUN; step to mf_fase_new values 0010,0100,...; the first return to 0001 at step 15 -> period=15, period_valid=1.
3. mf_control held high for 5 cycles, then low, then a 1-cycle pulse -> exactly 2 steps counted, bit_cnt=2.
4. start, then no control pulses -> done exactly 255 cycles after entering RUN with err=1, bit_cnt=0.
5. len=0 with WORD_BITS=32 -> done after 32 steps; len=40 -> also 32.
6. rst asserted at step 3 of 8 -> next cycle IDLE, all outputs 0, no done pulse; a start pulsed during RUN has no effect on the run.
